// File: rtl/e203_commit_monitor_if.sv
// Commit/issue observation bundle between the E203 core top and the run monitor.
// The core side drives every signal; the monitor only samples them.
interface e203_commit_monitor_if #(
   parameter int unsigned PC_W = 32,
   parameter int unsigned XLEN = 32
);
   logic            cmt_valid;
   logic [PC_W-1:0] cmt_pc;
   logic            ir_valid;
   logic            ir_ready;
   logic [XLEN-1:0] x3;
   logic            irq_busy;

   modport master (
      output cmt_valid, cmt_pc, ir_valid, ir_ready, x3, irq_busy
   );

   modport slave (
      input  cmt_valid, cmt_pc, ir_valid, ir_ready, x3, irq_busy
   );
endinterface

// File: rtl/e203_commit_monitor.sv
// Run monitor downstream of the E203 commit stage: cycle/instruction counters,
// tohost bookkeeping, irq stimulus window and sticky done/pass/fail verdict.
// Optional feature macro: E203_CMT_TRACE_EN adds a ring buffer of recent
// committed PCs; without it trc_rd_pc and trc_cnt read as constant zero.
module e203_commit_monitor #(
   parameter int unsigned     PC_W        = 32,
   parameter int unsigned     XLEN        = 32,
   parameter logic [PC_W-1:0] PC_TOHOST   = PC_W'(32'h8000_0086),
   parameter logic [PC_W-1:0] PC_ARM      = PC_W'(32'h8000_015C),
   parameter logic [XLEN-1:0] PASS_SIG    = XLEN'(32'hdead_beef),
   parameter int unsigned     STOP_THRESH = 32,
   parameter int unsigned     TIMEOUT_CYC = 10_000_000,
   parameter int unsigned     TRACE_DEPTH = 16,
   localparam int unsigned    IDX_W       = $clog2(TRACE_DEPTH)
) (
   input  logic                  hfclk,
   input  logic                  rst_n,
   e203_commit_monitor_if.slave  mon,
   output logic [31:0]           cycle_cnt,
   output logic [31:0]           instr_cnt,
   output logic [31:0]           end_cycle,
   output logic [31:0]           tohost_cnt,
   output logic                  irq_arm,
   output logic                  done,
   output logic                  pass,
   output logic                  fail,
   output logic [1:0]            state,
   input  logic [IDX_W-1:0]      trc_rd_idx,
   output logic [PC_W-1:0]       trc_rd_pc,
   output logic [IDX_W:0]        trc_cnt
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e      state_q;
   state_e      state_d;
   logic        set_pass;
   logic        set_fail;
   logic        end_seen;
   logic        active;
   logic        arm_hit;
   logic        tohost_hit;
   logic        pass_hit;
   logic        timeout_hit;
   logic        issue_fire;
   logic [31:0] tohost_cnt_d;

   // Decode the sampled core activity once; everything below is gated by "active".
   assign active       = (state_q != ST_DONE);
   assign arm_hit      = mon.cmt_valid && (mon.cmt_pc == PC_ARM);
   assign tohost_hit   = mon.cmt_valid && (mon.cmt_pc == PC_TOHOST);
   assign pass_hit     = (mon.x3 == PASS_SIG);
   assign timeout_hit  = (cycle_cnt == 32'(TIMEOUT_CYC));
   assign issue_fire   = mon.ir_valid && mon.ir_ready;
   assign tohost_cnt_d = tohost_cnt + 32'(active && tohost_hit);
   assign state        = state_q;

   // Next-state logic: a pass signature beats a coincident timeout only in BOOT/RUN.
   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      state_d  = state_q;
      set_pass = 1'b0;
      set_fail = 1'b0;
      case (state_q)
         ST_BOOT: begin
            if (pass_hit) begin
               state_d = ST_DRAIN;
            end else if (timeout_hit) begin
               state_d  = ST_DONE;
               set_fail = 1'b1;
            end else if (arm_hit) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (pass_hit) begin
               state_d = ST_DRAIN;
            end else if (timeout_hit) begin
               state_d  = ST_DONE;
               set_fail = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (timeout_hit) begin
               state_d  = ST_DONE;
               set_fail = 1'b1;
            end else if (!mon.irq_busy) begin
               state_d  = ST_DONE;
               set_pass = 1'b1;
            end
         end
         default: state_d = state_q;
      endcase
   end

   // FSM state register plus the sticky verdict flags that ride with it.
   always_ff @(posedge hfclk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
         state_q <= ST_BOOT;
         done    <= 1'b0;
         pass    <= 1'b0;
         fail    <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= (state_d == ST_DONE);
         if (set_pass) pass <= 1'b1;
         if (set_fail) fail <= 1'b1;
      end
   end

   // Free-running cycle counter; saturates and freezes once the run is over.
   always_ff @(posedge hfclk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
      end else if (active && (cycle_cnt != '1)) begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end

   // Issued-instruction counter; the first tohost cycle still counts.
   always_ff @(posedge hfclk or negedge rst_n) begin
      if (!rst_n) begin
         instr_cnt <= '0;
      end else if (active && issue_fire && !end_seen) begin
         instr_cnt <= instr_cnt + 32'd1;
      end
   end

   // Tohost hit counting; the first hit stamps the pre-increment cycle count.
   always_ff @(posedge hfclk or negedge rst_n) begin
      if (!rst_n) begin
         tohost_cnt <= '0;
         end_seen   <= 1'b0;
         end_cycle  <= '0;
      end else if (active && tohost_hit) begin
         tohost_cnt <= tohost_cnt_d;
         if (!end_seen) begin
            end_seen  <= 1'b1;
            end_cycle <= cycle_cnt;
         end
      end
   end

   // Irq window follows next-cycle state and count so it moves with them.
   always_ff @(posedge hfclk or negedge rst_n) begin
      if (!rst_n) begin
         irq_arm <= 1'b0;
      end else begin
         irq_arm <= (state_d == ST_RUN) && (tohost_cnt_d <= 32'(STOP_THRESH));
      end
   end

`ifdef E203_CMT_TRACE_EN
   logic [PC_W-1:0]  trc_mem [TRACE_DEPTH];
   logic [IDX_W-1:0] wr_ptr;
   logic [IDX_W:0]   trc_cnt_q;
   logic [IDX_W-1:0] rd_slot;
   logic             trc_wr;

   assign trc_wr  = active && mon.cmt_valid;
   assign trc_cnt = trc_cnt_q;

   // Ring pointers: write pointer wraps naturally, fill count saturates at depth.
   always_ff @(posedge hfclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         trc_cnt_q <= '0;
      end else if (trc_wr) begin
         wr_ptr <= wr_ptr + IDX_W'(1);
         if (trc_cnt_q != (IDX_W + 1)'(TRACE_DEPTH)) begin
            trc_cnt_q <= trc_cnt_q + (IDX_W + 1)'(1);
         end
      end
   end

   // Trace storage; entries beyond trc_cnt are masked on read instead.
   always_ff @(posedge hfclk) begin
      // NOTE: the array has no reset; stale contents are hidden by the trc_cnt read mask.
      if (trc_wr) trc_mem[wr_ptr] <= mon.cmt_pc;
   end

   // Newest-first read port; indexes past the fill level read as zero.
   always_comb begin
      rd_slot   = wr_ptr - IDX_W'(1) - trc_rd_idx;
      trc_rd_pc = '0;
      if ({1'b0, trc_rd_idx} < trc_cnt_q) trc_rd_pc = trc_mem[rd_slot];
   end
`else
   logic unused_trc_rd_idx;

   assign unused_trc_rd_idx = ^trc_rd_idx;
   assign trc_rd_pc         = '0;
   assign trc_cnt           = '0;
`endif

endmodule
